// File: rtl/rs422_frame_receiver.sv
// rs422_frame_receiver: 8N1 serial byte receiver with 16x oversampling and a one-deep valid/ready output.
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_in      asynchronous serial line, idle high
//   rx_data    last accepted byte
//   rx_valid   rx_data holds an unconsumed byte
//   rx_ready   consumer takes rx_data this cycle
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    one-cycle pulse when a good byte is dropped
//   busy       receiver is not idle
module rs422_frame_receiver #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t r_state, w_next;
  logic       r_sync1, r_sync2;
  logic [11:0] r_div;
  logic [3:0] r_tcnt;
  logic [2:0] r_bcnt;
  logic [7:0] r_shift, r_data;
  logic       r_valid, r_ferr, r_ovr;
  logic       w_tick, w_mid, w_end, w_clr, w_deliver, w_ferr, w_shift;
  assign w_tick = r_div == 12'(BAUD_DIV - 1);
  assign w_mid  = w_tick && r_tcnt == 4'd7;
  assign w_end  = w_tick && r_tcnt == 4'd15;
  // w_clr restarts the bit timing: divider and tick count both return to 0
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_deliver = 1'b0;
    w_ferr    = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE: if (!r_sync2) begin
        w_next = START;
        w_clr  = 1'b1;
      end
      START: if (w_mid) begin
        w_next = r_sync2 ? IDLE : DATA;
        w_clr  = 1'b1;
      end
      DATA: if (w_end) begin
        w_shift = 1'b1;
        w_next  = r_bcnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (w_end) begin
        w_next    = r_sync2 ? IDLE : WAIT_HIGH;
        w_deliver = r_sync2;
        w_ferr    = !r_sync2;
      end
      WAIT_HIGH: w_next = r_sync2 ? IDLE : WAIT_HIGH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_div   <= '0;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_div   <= (w_clr || w_tick) ? '0 : r_div + 12'd1;
      r_tcnt  <= w_clr ? '0 : r_tcnt + 4'(w_tick);
      r_bcnt  <= w_clr ? '0 : r_bcnt + 3'(w_shift);
      // LSB arrives first, so shifting in from the top leaves bit 0 in place after eight samples
      if (w_shift) r_shift <= {r_sync2, r_shift[7:1]};
      r_ferr <= w_ferr;
      r_ovr  <= w_deliver && r_valid && !rx_ready;
      // a byte consumed in the delivery cycle makes room for the new one
      if (w_deliver && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = r_state != IDLE;
endmodule

// File: tb/tb_rs422_frame_receiver.sv
// tb_rs422_frame_receiver: directed frame vectors and corner sequences for rs422_frame_receiver at BAUD_DIV=4.
module tb_rs422_frame_receiver;
  logic       clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
  rs422_frame_receiver #(.BAUD_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_miss = 0;
  int n_ferr = 0, n_ovr = 0, n_rise = 0, n_dbl = 0;
  logic p_ferr = 1'b0, p_ovr = 1'b0, p_valid = 1'b0;
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (rx_valid && !p_valid) n_rise++;
    if ((frame_err && p_ferr) || (overrun && p_ovr)) n_dbl++;
    p_ferr  = frame_err;
    p_ovr   = overrun;
    p_valid = rx_valid;
  end
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    logic       consume;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
    int         exp_rise;
  } vec_t;
  vec_t vecs[7];
  int b_f, b_o, b_r;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // called at a negedge; each bit is held for 64 clk (16 ticks of 4 clk)
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (64) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask
  task automatic snap();
    b_f = n_ferr;
    b_o = n_ovr;
    b_r = n_rise;
  endtask
  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0, 1};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 0, 0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 0, 0, 1};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 0, 1};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 0, 1, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 0, 0, 1};
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    for (int i = 0; i < 7; i++) begin
      snap();
      rx_ready = vecs[i].ready;
      send_byte(vecs[i].data, vecs[i].stop);
      repeat (100) @(negedge clk);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d rx_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("v%0d frame_err pulses", i), n_ferr - b_f, vecs[i].exp_ferr);
      chk($sformatf("v%0d overrun pulses", i), n_ovr - b_o, vecs[i].exp_ovr);
      chk($sformatf("v%0d deliveries", i), n_rise - b_r, vecs[i].exp_rise);
      chk($sformatf("v%0d busy", i), busy, 0);
      if (vecs[i].consume) begin
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d consumed rx_valid", i), rx_valid, 0);
        chk($sformatf("v%0d consumed rx_data", i), rx_data, vecs[i].exp_data);
      end
      rx_ready = 1'b0;
    end
    // second byte lands in the very cycle the first is consumed
    send_byte(8'h11, 1'b1);
    snap();
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (610) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("swap rx_valid", rx_valid, 1);
    chk("swap rx_data", rx_data, 8'h22);
    chk("swap overrun pulses", n_ovr - b_o, 0);
    chk("swap valid never dropped", n_rise - b_r, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    // 20 clk low glitch aborts at mid start bit
    snap();
    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch busy", busy, 1);
    repeat (10) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch idle", busy, 0);
    chk("glitch rx_valid", rx_valid, 0);
    chk("glitch frame_err pulses", n_ferr - b_f, 0);
    chk("glitch deliveries", n_rise - b_r, 0);
    // reset in the middle of data bit 4
    send_byte(8'h77, 1'b1);
    repeat (20) @(negedge clk);
    chk("pre-reset rx_valid", rx_valid, 1);
    chk("pre-reset rx_data", rx_data, 8'h77);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (350) @(negedge clk);
        chk("mid-frame busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset rx_valid", rx_valid, 0);
        chk("async reset rx_data", rx_data, 0);
        chk("async reset busy", busy, 0);
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b1;
      end
    join
    snap();
    repeat (100) @(negedge clk);
    chk("after reset no frame", n_rise - b_r, 0);
    chk("after reset busy", busy, 0);
    send_byte(8'h5A, 1'b1);
    repeat (100) @(negedge clk);
    chk("post-reset rx_valid", rx_valid, 1);
    chk("post-reset rx_data", rx_data, 8'h5A);
    chk("single-cycle pulses", n_dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/rs422_frame_receiver.md
RS422_FRAME_RECEIVER -- requirements
Module: rs422_frame_receiver

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 27, giving clk cycles per 16x-oversample tick (legal range 2..4095).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have input rx_in, 1 bit, asynchronous serial line, idle high.
REQ-005 The block SHALL have output rx_data, 8 bits, last accepted byte.
REQ-006 The block SHALL have output rx_valid, 1 bit, rx_data holds an unconsumed byte.
REQ-007 The block SHALL have input rx_ready, 1 bit, consumer accepts rx_data this cycle.
REQ-008 The block SHALL have output frame_err, 1 bit, one-cycle pulse on bad stop bit.
REQ-009 The block SHALL have output overrun, 1 bit, one-cycle pulse when a good byte is dropped.
REQ-010 The block SHALL have output busy, 1 bit, high in every state except IDLE.

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity, bit period = 16 ticks.
REQ-012 rx_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-013 Tick divider SHALL count 0..BAUD_DIV-1, assert tick when count = BAUD_DIV-1, then wrap to 0; it SHALL clear to 0 on entry to START.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: rx_s = 0 SHALL move to START with tick counter cleared.
REQ-016 START: on the 8th tick (mid start bit), rx_s = 1 SHALL return to IDLE (glitch, no output); rx_s = 0 SHALL move to DATA with tick counter cleared.
REQ-017 DATA: every 16th tick SHALL shift rx_s into bit position n (n = 0..7); after bit 7, move to STOP.
REQ-018 STOP: on the 16th tick, rx_s = 1 SHALL deliver the byte and return to IDLE; rx_s = 0 SHALL pulse frame_err, discard the byte, and move to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL remain until rx_s = 1, then return to IDLE (line held low/break never produces frames).
REQ-020 Delivery SHALL occur the cycle after the stop-bit sample: rx_data loaded, rx_valid set.
REQ-021 rx_valid SHALL stay high, rx_data stable, until a cycle with rx_valid & rx_ready; rx_valid then clears next cycle.
REQ-022 Delivery while rx_valid = 1 and rx_ready = 0 SHALL pulse overrun, keep old rx_data, drop new byte.
REQ-023 Delivery in the same cycle as rx_valid & rx_ready SHALL load the new byte, keep rx_valid high, no overrun.
REQ-024 rx_ready while rx_valid = 0 SHALL have no effect.
REQ-025 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, synchronizer flops 1, tick and bit counters 0, shift register 0, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no output; after release, the next falling edge of rx_in starts a fresh frame.
REQ-028 Reset release SHALL be usable asynchronously; first state change no earlier than the first clk edge after release.

Verification (BAUD_DIV = 4, bit period 64 clk)
REQ-029 Send 8'hA5, rx_ready held 0 -> rx_valid rises after stop sample, rx_data = 8'hA5, held until rx_ready pulsed, then rx_valid = 0.
REQ-030 Low glitch of 20 clk on idle line -> START aborts at mid-bit, returns IDLE, no rx_valid/frame_err.
REQ-031 Send 8'h3C with stop bit 0, then line high -> frame_err one-cycle pulse, rx_valid stays 0, WAIT_HIGH then IDLE, next frame 8'h01 received correctly.
REQ-032 Send 8'h11 then 8'h22 back-to-back, rx_ready 0 -> rx_data = 8'h11, overrun one-cycle pulse at second delivery; rx_ready pulsed in second delivery cycle instead -> rx_data = 8'h22, no overrun.
REQ-033 Assert rst_n low during DATA bit 4 of 8'hFF -> all outputs reset values immediately; next frame 8'h5A received correctly.
REQ-034 Send 8'h00 and 8'hFF consecutively with rx_ready 1 -> both bytes delivered in order, no errors, busy low between frames.
